// File: rtl/array_swap_engine.sv
// array_swap_engine
// Executes one array-swap descriptor at a time against a word-addressed u32 RAM.
// Each element is moved with two reads followed by two writes, so the final image
// equals a simultaneous swap of the two (disjoint) ranges.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   op_*                descriptor (valid/ready); op_ready is high only in idle
//   flags               condition flag vector, one bit sampled at accept
//   mem_rd_*            single read port, data returns the cycle after mem_rd_en
//   mem_wr_*            single write port
//   busy, done          engine active / one-cycle completion pulse
//   done_status         0 ok, 1 skipped, 2 error; meaningful only with done
module array_swap_engine #(
  parameter int unsigned EV_LENGTH_U32 = 64,
  parameter int unsigned ADDR_W        = $clog2(EV_LENGTH_U32),
  parameter int unsigned LEN_W         = ADDR_W + 1,
  parameter int unsigned FLAG_W        = 8,
  parameter int unsigned CIDX_W        = $clog2(FLAG_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [ADDR_W-1:0] op_arr1,
  input  logic [ADDR_W-1:0] op_arr2,
  input  logic [LEN_W-1:0]  op_length,
  input  logic              op_cond_en,
  input  logic [CIDX_W-1:0] op_cond_idx,
  input  logic [FLAG_W-1:0] flags,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [31:0]       mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [31:0]       mem_wr_data,
  output logic              busy,
  output logic              done,
  output logic [1:0]        done_status
);

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StRdA,
    StRdB,
    StWrA,
    StWrB,
    StDone
  } state_e;

  localparam logic [1:0] StatusOk   = 2'd0;
  localparam logic [1:0] StatusSkip = 2'd1;
  localparam logic [1:0] StatusErr  = 2'd2;

  localparam logic [LEN_W:0]    EvLen   = EV_LENGTH_U32[LEN_W:0];
  localparam logic [LEN_W-1:0]  LenOne  = 1;
  localparam logic [ADDR_W-1:0] AddrOne = 1;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] arr1_q, arr2_q;
  logic [LEN_W-1:0]  len_q;
  logic              cond_en_q, flag_q;
  logic [ADDR_W-1:0] idx_q;
  logic [31:0]       a_q, b_q;
  logic [1:0]        status_q;

  logic              accept;
  logic [LEN_W:0]    arr1_ext, arr2_ext, len_ext, end1, end2;
  logic [1:0]        check_status;
  logic              check_exec;
  logic              last_elem;

  assign accept = (state_q == StIdle) && op_valid;

  // Range checks are done one bit wider than the length so nothing wraps.
  assign arr1_ext = {{(LEN_W + 1 - ADDR_W){1'b0}}, arr1_q};
  assign arr2_ext = {{(LEN_W + 1 - ADDR_W){1'b0}}, arr2_q};
  assign len_ext  = {1'b0, len_q};
  assign end1     = arr1_ext + len_ext;
  assign end2     = arr2_ext + len_ext;

  assign last_elem = (({1'b0, idx_q} + LenOne) == len_q);

  // Descriptor classification, evaluated while in StCheck.
  always_comb begin
    check_status = StatusOk;
    check_exec   = 1'b0;
    if (cond_en_q && !flag_q) begin
      check_status = StatusSkip;
    end else if ((end1 > EvLen) || (end2 > EvLen)) begin
      check_status = StatusErr;
    end else if ((len_q == '0) || (arr1_q == arr2_q)) begin
      check_status = StatusOk;
    end else if ((arr1_ext < end2) && (arr2_ext < end1)) begin
      check_status = StatusErr;
    end else begin
      check_exec = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (op_valid) state_d = StCheck;
      StCheck: state_d = check_exec ? StRdA : StDone;
      StRdA:   state_d = StRdB;
      StRdB:   state_d = StWrA;
      StWrA:   state_d = StWrB;
      StWrB:   state_d = last_elem ? StDone : StRdA;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are pure functions of state so reset silences the ports immediately.
  always_comb begin
    op_ready    = (state_q == StIdle);
    busy        = (state_q != StIdle);
    done        = 1'b0;
    done_status = StatusOk;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    unique case (state_q)
      StRdA: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = arr1_q + idx_q;
      end
      StRdB: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = arr2_q + idx_q;
      end
      StWrA: begin
        mem_wr_en   = 1'b1;
        mem_wr_addr = arr2_q + idx_q;
        mem_wr_data = a_q;
      end
      StWrB: begin
        mem_wr_en   = 1'b1;
        mem_wr_addr = arr1_q + idx_q;
        mem_wr_data = b_q;
      end
      StDone: begin
        done        = 1'b1;
        done_status = status_q;
      end
      default: ;
    endcase
  end

  // Descriptor capture and element datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      arr1_q    <= '0;
      arr2_q    <= '0;
      len_q     <= '0;
      cond_en_q <= 1'b0;
      flag_q    <= 1'b0;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      status_q  <= StatusOk;
    end else begin
      if (accept) begin
        arr1_q    <= op_arr1;
        arr2_q    <= op_arr2;
        len_q     <= op_length;
        cond_en_q <= op_cond_en;
        flag_q    <= flags[op_cond_idx];
      end
      if (state_q == StCheck) begin
        status_q <= check_status;
        idx_q    <= '0;
      end
      // Read data for arr1+i lands in StRdB, for arr2+i in StWrA.
      if (state_q == StRdB) a_q <= mem_rd_data;
      if (state_q == StWrA) b_q <= mem_rd_data;
      if (state_q == StWrB) idx_q <= idx_q + AddrOne;
    end
  end

endmodule

// File: tb/tb_array_swap_engine.sv
module tb_array_swap_engine;

  localparam int EV = 64;
  localparam int AW = 6;
  localparam int LW = 7;
  localparam int FW = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic [AW-1:0] op_arr1 = '0;
  logic [AW-1:0] op_arr2 = '0;
  logic [LW-1:0] op_length = '0;
  logic          op_cond_en = 1'b0;
  logic [CW-1:0] op_cond_idx = '0;
  logic [FW-1:0] flags = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [31:0]   rd_data;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [31:0]   mem_wr_data;
  logic          busy;
  logic          done;
  logic [1:0]    done_status;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  array_swap_engine dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_arr1    (op_arr1),
    .op_arr2    (op_arr2),
    .op_length  (op_length),
    .op_cond_en (op_cond_en),
    .op_cond_idx(op_cond_idx),
    .flags      (flags),
    .mem_rd_en  (mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(rd_data),
    .mem_wr_en  (mem_wr_en),
    .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data),
    .busy       (busy),
    .done       (done),
    .done_status(done_status)
  );

  // RAM model with one read and one write port, plus traffic counters.
  logic [31:0] mem [EV];
  logic        init_req  = 1'b0;
  logic        init_rand = 1'b0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;

  always @(posedge clk) begin
    if (init_req) begin
      for (int k = 0; k < EV; k++) mem[k] <= init_rand ? $urandom : 32'(k);
    end else if (mem_wr_en) begin
      mem[mem_wr_addr] <= mem_wr_data;
    end
    rd_data <= mem[mem_rd_addr];
    if (mem_rd_en) rd_cnt <= rd_cnt + 1;
    if (mem_wr_en) wr_cnt <= wr_cnt + 1;
  end

  // Port protocol monitor: no simultaneous read/write, no traffic while idle.
  int proto_bad = 0;
  always @(negedge clk) begin
    if (!rst && ((mem_rd_en && mem_wr_en) || (!busy && (mem_rd_en || mem_wr_en))))
      proto_bad <= proto_bad + 1;
  end

  // Reference image of memory.
  logic [31:0] exp_mem [EV];

  task automatic init_mem(input bit rnd);
    @(negedge clk);
    init_rand = rnd;
    init_req  = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    for (int k = 0; k < EV; k++) exp_mem[k] = mem[k];
  endtask

  task automatic drive_and_accept(input int a1, input int a2, input int len, input bit cen,
                                  input int cidx, input logic [FW-1:0] fl);
    @(negedge clk);
    op_arr1     = a1[AW-1:0];
    op_arr2     = a2[AW-1:0];
    op_length   = len[LW-1:0];
    op_cond_en  = cen;
    op_cond_idx = cidx[CW-1:0];
    flags       = fl;
    op_valid    = 1'b1;
    if (op_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_ready: op_ready=%b required 1", op_ready);
    end
    n_checks++;
    @(posedge clk);
    #1;
    // Scramble everything after the accepting edge; the engine must ignore it.
    op_valid    = 1'b0;
    op_arr1     = AW'($urandom);
    op_arr2     = AW'($urandom);
    op_length   = LW'($urandom);
    op_cond_en  = ~cen;
    op_cond_idx = CW'($urandom);
    flags       = ~fl;
  endtask

  // Runs one descriptor and compares latency, status, traffic and memory to the model.
  task automatic do_op(input string name, input int a1, input int a2, input int len,
                       input bit cen, input int cidx, input logic [FW-1:0] fl);
    logic [1:0]  exp_st;
    bit          exec;
    int          exp_lat, rd0, wr0, k_done, bad_addr;
    logic [31:0] tmp;

    // Model: rules in priority order on unbounded integers.
    exec = 1'b0;
    if (cen && !fl[cidx])                       exp_st = 2'd1;
    else if (a1 + len > EV || a2 + len > EV)    exp_st = 2'd2;
    else if (len == 0 || a1 == a2)              exp_st = 2'd0;
    else if (a1 < a2 + len && a2 < a1 + len)    exp_st = 2'd2;
    else begin
      exp_st = 2'd0;
      exec   = 1'b1;
    end
    exp_lat = exec ? 4 * len + 2 : 2;
    if (exec) begin
      for (int k = 0; k < len; k++) begin
        tmp             = exp_mem[a1 + k];
        exp_mem[a1 + k] = exp_mem[a2 + k];
        exp_mem[a2 + k] = tmp;
      end
    end

    rd0 = rd_cnt;
    wr0 = wr_cnt;
    drive_and_accept(a1, a2, len, cen, cidx, fl);

    k_done = 0;
    for (int k = 1; k <= 300 && k_done == 0; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        k_done = k;
        if (done_status !== exp_st) begin
          n_fail++;
          $display("FAIL %s status: got %0d required %0d", name, done_status, exp_st);
        end
        n_checks++;
        if (busy !== 1'b1 || op_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL %s busy_at_done: busy=%b op_ready=%b required 1/0", name, busy,
                   op_ready);
        end
        n_checks++;
      end
    end

    if (k_done != exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: done in cycle %0d required %0d (0 = timeout)", name, k_done,
               exp_lat);
    end
    n_checks++;
    if (rd_cnt - rd0 != (exec ? 2 * len : 0) || wr_cnt - wr0 != (exec ? 2 * len : 0)) begin
      n_fail++;
      $display("FAIL %s traffic: reads=%0d writes=%0d required %0d each", name, rd_cnt - rd0,
               wr_cnt - wr0, exec ? 2 * len : 0);
    end
    n_checks++;

    bad_addr = -1;
    for (int k = EV - 1; k >= 0; k--) if (mem[k] !== exp_mem[k]) bad_addr = k;
    if (bad_addr >= 0) begin
      n_fail++;
      $display("FAIL %s memory: word %0d = %0h required %0h", name, bad_addr, mem[bad_addr],
               exp_mem[bad_addr]);
    end
    n_checks++;

    @(negedge clk);
    if (done !== 1'b0 || op_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after_done: done=%b op_ready=%b busy=%b required 0/1/0", name, done,
               op_ready, busy);
    end
    n_checks++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    if (op_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || done_status !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready=%b busy=%b done=%b status=%0d required 1/0/0/0",
               op_ready, busy, done, done_status);
    end
    n_checks++;
    if (mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0 || mem_rd_addr !== '0 ||
        mem_wr_addr !== '0 || mem_wr_data !== '0) begin
      n_fail++;
      $display("FAIL reset_mem_ports: rd_en=%b wr_en=%b rd_addr=%0d wr_addr=%0d wr_data=%0h",
               mem_rd_en, mem_wr_en, mem_rd_addr, mem_wr_addr, mem_wr_data);
    end
    n_checks++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    init_mem(1'b0);
    do_op("basic", 0, 10, 3, 1'b0, 0, 8'h00);
    if (mem[0] !== 32'd10 || mem[2] !== 32'd12 || mem[10] !== 32'd0 || mem[12] !== 32'd2) begin
      n_fail++;
      $display("FAIL basic_words: w0=%0d w2=%0d w10=%0d w12=%0d required 10/12/0/2", mem[0],
               mem[2], mem[10], mem[12]);
    end
    n_checks++;
  endtask

  task automatic test_cond();
    init_mem(1'b0);
    do_op("cond_skip", 0, 10, 3, 1'b1, 3, 8'h00);
    do_op("cond_exec", 0, 10, 3, 1'b1, 3, 8'h08);
  endtask

  task automatic test_errors();
    init_mem(1'b0);
    do_op("err_bounds", 60, 0, 5, 1'b0, 0, 8'h00);
    do_op("err_overlap", 4, 6, 4, 1'b0, 0, 8'h00);
    do_op("err_bounds2", 0, 63, 2, 1'b0, 0, 8'h00);
  endtask

  task automatic test_noop();
    do_op("noop_len0", 3, 9, 0, 1'b0, 0, 8'h00);
    do_op("noop_same", 7, 7, 5, 1'b0, 0, 8'h00);
  endtask

  task automatic test_boundary();
    init_mem(1'b0);
    do_op("half_swap", 0, 32, 32, 1'b0, 0, 8'h00);
    if (mem[31] !== 32'd63 || mem[63] !== 32'd31) begin
      n_fail++;
      $display("FAIL half_swap_edges: w31=%0d w63=%0d required 63/31", mem[31], mem[63]);
    end
    n_checks++;
  endtask

  task automatic test_mid_reset();
    int wr_snap;
    init_mem(1'b0);
    drive_and_accept(20, 40, 3, 1'b0, 0, 8'h00);
    // Cycle 8 is WR_A of element 1; raise rst for that cycle's edge.
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if (op_ready !== 1'b1 || busy !== 1'b0 || mem_wr_en !== 1'b0 || mem_rd_en !== 1'b0 ||
        done !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_idle: ready=%b busy=%b wr_en=%b rd_en=%b done=%b required 1/0/0/0/0",
               op_ready, busy, mem_wr_en, mem_rd_en, done);
    end
    n_checks++;
    wr_snap = wr_cnt;
    repeat (6) @(negedge clk);
    if (wr_cnt !== wr_snap) begin
      n_fail++;
      $display("FAIL midrst_no_writes: writes after reset=%0d required 0", wr_cnt - wr_snap);
    end
    n_checks++;
    if (mem[20] !== 32'd40 || mem[40] !== 32'd20 || mem[21] !== 32'd21 || mem[22] !== 32'd22 ||
        mem[42] !== 32'd42) begin
      n_fail++;
      $display("FAIL midrst_image: w20=%0d w40=%0d w21=%0d w22=%0d w42=%0d required 40/20/21/22/42",
               mem[20], mem[40], mem[21], mem[22], mem[42]);
    end
    n_checks++;
    init_mem(1'b0);
    do_op("after_reset", 20, 40, 3, 1'b0, 0, 8'h00);
  endtask

  task automatic test_random();
    int a1, a2, len;
    init_mem(1'b1);
    for (int n = 0; n < 25; n++) begin
      len = $urandom_range(12, 0);
      a1  = $urandom_range(EV - 1, 0);
      a2  = $urandom_range(EV - 1, 0);
      do_op("random", a1, a2, len, 1'($urandom), $urandom_range(FW - 1, 0), 8'($urandom));
    end
  endtask

  task automatic test_back_to_back();
    do_op("b2b_0", 1, 50, 4, 1'b0, 0, 8'h00);
    do_op("b2b_1", 50, 1, 4, 1'b0, 0, 8'h00);
    do_op("b2b_2", 10, 30, 6, 1'b1, 5, 8'h20);
  endtask

  task automatic test_protocol();
    if (proto_bad !== 0) begin
      n_fail++;
      $display("FAIL port_protocol: %0d bad cycles required 0", proto_bad);
    end
    n_checks++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cond();
    test_errors();
    test_noop();
    test_boundary();
    test_mid_reset();
    test_random();
    test_back_to_back();
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/array_swap_engine.md
Name: array_swap_engine

Overview:
Multi-cycle sequential executor for array-swap operation descriptors (arr_1, arr_2, length, conditional flag select) against the word-addressed u32 execution-environment RAM. It sits directly downstream of the descriptor builder: it accepts one descriptor via valid/ready and performs the swap one element at a time through a single read port and a single write port. It reports completion with a status code of ok, skipped or error.

Parameters:
EV_LENGTH_U32, 64, number of u32 words in the execution environment
ADDR_W, $clog2(EV_LENGTH_U32), word address width
LEN_W, ADDR_W+1, length field width; must hold the value EV_LENGTH_U32
FLAG_W, 8, number of condition flags

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
op_valid  in  1  descriptor valid
op_ready  out  1  engine can accept a descriptor
op_arr1  in  ADDR_W  base word address of array 1
op_arr2  in  ADDR_W  base word address of array 2
op_length  in  LEN_W  number of words to swap
op_cond_en  in  1  0 = unconditional; 1 = gate execution on a flag
op_cond_idx  in  $clog2(FLAG_W)  index of the gating flag
flags  in  FLAG_W  condition flag vector
mem_rd_en  out  1  read request
mem_rd_addr  out  ADDR_W  read address
mem_rd_data  in  32  read data, valid the cycle after mem_rd_en
mem_wr_en  out  1  write strobe
mem_wr_addr  out  ADDR_W  write address
mem_wr_data  out  32  write data
busy  out  1  engine is not in IDLE
done  out  1  one-cycle completion pulse
done_status  out  2  0 = ok, 1 = skipped, 2 = error; valid only while done is high

Behaviour:
- Reset, including reset mid-operation: state returns to IDLE and the element counter clears. op_ready=1; busy, done, mem_rd_en and mem_wr_en are 0; all address and data outputs are 0; done_status=0. Writes already made to memory are not undone, and no further writes are issued.
- Handshake: op_ready=1 only in IDLE. A descriptor is accepted on a clock edge where op_valid && op_ready. The edge captures all op_* fields and the single bit flags[op_cond_idx]. Later changes to the inputs are ignored.
- FSM states: IDLE, CHECK, RD_A, RD_B, WR_A, WR_B, DONE.
- IDLE -> CHECK on accept.
- CHECK: evaluate the following in priority order, all arithmetic at LEN_W+1 bits, no wrap:
  1. op_cond_en=1 and the captured flag is 0 -> status skipped, go to DONE.
  2. arr1+length > EV_LENGTH_U32 or arr2+length > EV_LENGTH_U32 -> status error, go to DONE.
  3. length=0 or arr1==arr2 -> status ok, no memory traffic, go to DONE.
  4. Ranges overlap (arr1 < arr2+length and arr2 < arr1+length) -> status error, go to DONE.
  5. Otherwise set i=0 and go to RD_A.
- RD_A: mem_rd_en=1, mem_rd_addr=arr1+i.
- RD_B: mem_rd_en=1, mem_rd_addr=arr2+i; capture mem_rd_data into a_reg.
- WR_A: mem_wr_en=1, mem_wr_addr=arr2+i, mem_wr_data=a_reg; capture mem_rd_data into b_reg.
- WR_B: mem_wr_en=1, mem_wr_addr=arr1+i, mem_wr_data=b_reg; i++. Go to DONE if i+1==length, else go to RD_A.
- DONE: done=1 with done_status driven, then go to IDLE. op_ready returns to 1 the following cycle, so back-to-back descriptors have a 1-cycle gap.
- Latency, counting from the accepting edge as cycle 0:
  - Executed swap: done is high in cycle 4*length+2; total memory traffic is 2*length reads and 2*length writes.
  - Skip, error, or no-op: done is high in cycle 2.
- Ordering: for every element, both reads precede both writes, and ranges are disjoint. The final memory image therefore equals a simultaneous swap of the two ranges.
- mem_rd_en and mem_wr_en are never asserted in the same cycle. Neither is asserted outside RD_A, RD_B, WR_A and WR_B.

Test Plan:
- Memory word k = k. Descriptor arr1=0, arr2=10, length=3, unconditional -> words 0..2 = 10,11,12; words 10..12 = 0,1,2; done in cycle 14 with status 0; exactly 6 reads and 6 writes; all other words unchanged.
- op_cond_en=1, op_cond_idx=3, flags=8'h00 -> done in cycle 2 with status 1, no memory traffic. Repeat with flags=8'h08 -> swap executes.
- Error cases, each -> done in cycle 2 with status 2 and no writes:
  - arr1=60, length=5 with EV_LENGTH_U32=64.
  - arr1=4, arr2=6, length=4 (overlapping ranges).
- length=0, and separately arr1=arr2=7 with length=5 -> status 0, done in cycle 2, no memory traffic.
- Boundary case arr1=0, arr2=32, length=32 -> full half swap; done in cycle 130; words 31 and 63 swapped correctly.
- Assert rst during WR_A of element 1 in a length-3 swap -> no memory writes after the rst edge; IDLE with op_ready=1 next cycle. A new descriptor is then accepted and completes normally.
